// File: rtl/alu_control_unit_pkg.sv
// alu_control_unit_pkg: shared opcodes, instruction classes, field positions and FSM states
package alu_control_unit_pkg;
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_SUB  = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_XOR  = 3'd4;
  localparam logic [2:0] ALU_MUL  = 3'd5;
  localparam logic [2:0] ALU_DIV  = 3'd6;
  localparam logic [2:0] ALU_COMP = 3'd7;
  localparam logic [1:0] CLS_ALU  = 2'd0;
  localparam logic [1:0] CLS_LDI  = 2'd1;
  localparam logic [1:0] CLS_JZ   = 2'd2;
  localparam logic [1:0] CLS_HALT = 2'd3;
  localparam int F_CLS = 14;
  localparam int F_OP  = 11;
  localparam int F_RD  = 9;
  localparam int F_RS1 = 7;
  localparam int F_RS2 = 5;
  localparam int F_LRD = 12;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_WRITEBACK, S_HALT} state_t;
  function automatic logic [1:0] f_cls(input logic [15:0] ir);
    return ir[F_CLS+:2];
  endfunction
endpackage

// File: rtl/alu_control_unit_if.sv
// alu_control_unit_if: instruction-memory and ALU bus between controller and its neighbours
interface alu_control_unit_if #(parameter int DATA_W = 8, parameter int PC_W = 8);
  logic              imem_rd;
  logic [PC_W-1:0]   imem_addr;
  logic [15:0]       imem_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              carry_out;
  modport master(output imem_rd, imem_addr, alu_a, alu_b, alu_sel, input imem_data, alu_out, carry_out);
  modport slave(input imem_rd, imem_addr, alu_a, alu_b, alu_sel, output imem_data, alu_out, carry_out);
endinterface

// File: rtl/alu_control_unit_regfile.sv
// alu_control_unit_regfile: 4-entry register file, two async read ports, debug port, one sync write
module alu_control_unit_regfile #(parameter int DATA_W = 8) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [1:0]        i_wa,
  input  logic [DATA_W-1:0] i_wd,
  input  logic [1:0]        i_ra1,
  input  logic [1:0]        i_ra2,
  input  logic [1:0]        i_dbg_sel,
  output logic [DATA_W-1:0] o_rd1,
  output logic [DATA_W-1:0] o_rd2,
  output logic [DATA_W-1:0] o_dbg
);
  logic [DATA_W-1:0] r_mem [4];
  always_ff @(posedge clk)
    if (rst) r_mem <= '{default: '0};
    else if (i_we) r_mem[i_wa] <= i_wd;
  assign o_rd1 = r_mem[i_ra1];
  assign o_rd2 = r_mem[i_ra2];
  assign o_dbg = r_mem[i_dbg_sel];
endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: multi-cycle fetch/decode/execute/writeback controller for the shared 8-bit ALU
module alu_control_unit
  import alu_control_unit_pkg::*;
#(parameter int DATA_W = 8, parameter int PC_W = 8) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  alu_control_unit_if.master  bus,
  output logic                o_busy,
  output logic                o_halted,
  output logic                o_flag_z,
  output logic                o_flag_c,
  input  logic [1:0]          i_dbg_sel,
  output logic [DATA_W-1:0]   o_dbg_data
);
  state_t            r_state, w_next;
  logic [PC_W-1:0]   r_pc;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_result, r_alu_a, r_alu_b;
  logic [2:0]        r_alu_sel;
  logic              r_flag_z, r_flag_c;
  logic [1:0]        w_cls, w_cls_d, w_wa;
  logic [2:0]        w_op;
  logic [DATA_W-1:0] w_rs1_data, w_rs2_data, w_wd;
  logic              w_we, w_idle;
  assign w_cls   = f_cls(r_ir);
  assign w_cls_d = f_cls(bus.imem_data);
  assign w_op    = r_ir[F_OP+:3];
  assign w_idle  = r_state == S_IDLE || r_state == S_HALT;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: w_next = i_start ? S_FETCH : r_state;
      S_FETCH:        w_next = S_DECODE;
      S_DECODE:       w_next = w_cls_d == CLS_ALU ? S_EXECUTE :
                               w_cls_d == CLS_LDI ? S_WRITEBACK :
                               w_cls_d == CLS_JZ  ? S_FETCH : S_HALT;
      S_EXECUTE:      w_next = S_WRITEBACK;
      S_WRITEBACK:    w_next = S_FETCH;
      default:        w_next = S_IDLE;
    endcase
  end
  // Operands come straight from the regfile in EXECUTE and are frozen afterwards so the ALU inputs never toggle
  assign bus.alu_a     = r_state == S_EXECUTE ? w_rs1_data : r_alu_a;
  assign bus.alu_b     = r_state == S_EXECUTE ? w_rs2_data : r_alu_b;
  assign bus.alu_sel   = r_state == S_EXECUTE ? w_op : r_alu_sel;
  assign bus.imem_rd   = r_state == S_FETCH;
  assign bus.imem_addr = r_pc;
  assign o_busy   = !w_idle;
  assign o_halted = r_state == S_HALT;
  assign o_flag_z = r_flag_z;
  assign o_flag_c = r_flag_c;
  assign w_we = r_state == S_WRITEBACK && (w_cls == CLS_LDI || (w_cls == CLS_ALU && w_op != ALU_COMP));
  assign w_wa = w_cls == CLS_LDI ? r_ir[F_LRD+:2] : r_ir[F_RD+:2];
  assign w_wd = w_cls == CLS_LDI ? DATA_W'(r_ir[7:0]) : r_result;
  always_ff @(posedge clk)
    if (rst) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= '0;
      r_result  <= '0;
      r_flag_z  <= 1'b0;
      r_flag_c  <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_sel <= ALU_ADD;
    end else begin
      r_state <= w_next;
      if (w_idle && i_start) r_pc <= '0;
      if (r_state == S_DECODE) begin
        r_ir <= bus.imem_data;
        if (w_cls_d == CLS_JZ) r_pc <= r_flag_z ? PC_W'(bus.imem_data[7:0]) : r_pc + PC_W'(1);
      end
      if (r_state == S_EXECUTE) begin
        r_result  <= bus.alu_out;
        r_flag_z  <= bus.alu_out == '0;
        r_flag_c  <= bus.carry_out;
        r_alu_a   <= w_rs1_data;
        r_alu_b   <= w_rs2_data;
        r_alu_sel <= w_op;
      end
      if (r_state == S_WRITEBACK) r_pc <= r_pc + PC_W'(1);
    end
  alu_control_unit_regfile #(.DATA_W(DATA_W)) u_rf (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_wa      (w_wa),
    .i_wd      (w_wd),
    .i_ra1     (r_ir[F_RS1+:2]),
    .i_ra2     (r_ir[F_RS2+:2]),
    .i_dbg_sel (i_dbg_sel),
    .o_rd1     (w_rs1_data),
    .o_rd2     (w_rs2_data),
    .o_dbg     (o_dbg_data)
  );
endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: random and directed programs checked against an instruction-level model
module tb_alu_control_unit;
  import alu_control_unit_pkg::*;
  logic clk = 0, rst = 1, start = 0;
  logic busy, halted, flag_z, flag_c;
  logic [1:0] dbg_sel = 0;
  logic [7:0] dbg_data;
  logic [15:0] mem [256];
  logic [2:0] sel_hist [1024];
  logic [7:0] m_r [4];
  logic m_z, m_c;
  logic [7:0] m_pc;
  int n_chk = 0, n_err = 0;
  alu_control_unit_if bus();
  alu_control_unit dut (
    .clk(clk), .rst(rst), .i_start(start), .bus(bus), .o_busy(busy), .o_halted(halted),
    .o_flag_z(flag_z), .o_flag_c(flag_c), .i_dbg_sel(dbg_sel), .o_dbg_data(dbg_data)
  );
  always #5 clk = ~clk;
  function automatic logic [8:0] alu_f(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = a * b;
    case (s)
      ALU_ADD:  return {1'b0, a} + {1'b0, b};
      ALU_SUB, ALU_COMP: return {a < b, a - b};
      ALU_AND:  return {1'b0, a & b};
      ALU_OR:   return {1'b0, a | b};
      ALU_XOR:  return {1'b0, a ^ b};
      ALU_MUL:  return {|p[15:8], p[7:0]};
      default:  return b == 0 ? 9'h1FF : {1'b0, a / b};
    endcase
  endfunction
  always_comb {bus.carry_out, bus.alu_out} = alu_f(bus.alu_sel, bus.alu_a, bus.alu_b);
  always @(posedge clk) if (bus.imem_rd) bus.imem_data <= mem[bus.imem_addr];
  function automatic logic [15:0] e_alu(input logic [2:0] op, input logic [1:0] rd, rs1, rs2);
    return {CLS_ALU, op, rd, rs1, rs2, 5'b0};
  endfunction
  function automatic logic [15:0] e_ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {CLS_LDI, rd, 4'b0, imm};
  endfunction
  function automatic logic [15:0] e_jz(input logic [7:0] t);
    return {CLS_JZ, 6'b0, t};
  endfunction
  localparam logic [15:0] E_HALT = 16'hC000;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = E_HALT;
  endtask
  task automatic do_reset();
    @(negedge clk) rst = 1;
    @(negedge clk) rst = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_z = 0;
    m_c = 0;
    m_pc = 0;
  endtask
  // Instruction-set model: executes the program from pc 0 and totals the cycle cost per class
  task automatic model_run(output int cyc);
    logic [15:0] w;
    logic [8:0] r;
    cyc = 0;
    m_pc = 0;
    for (int s = 0; s < 2000; s++) begin
      w = mem[m_pc];
      case (w[15:14])
        CLS_ALU: begin
          r = alu_f(w[13:11], m_r[w[8:7]], m_r[w[6:5]]);
          m_z = r[7:0] == 0;
          m_c = r[8];
          if (w[13:11] != ALU_COMP) m_r[w[10:9]] = r[7:0];
          m_pc++;
          cyc += 4;
        end
        CLS_LDI: begin
          m_r[w[13:12]] = w[7:0];
          m_pc++;
          cyc += 3;
        end
        CLS_JZ: begin
          m_pc = m_z ? w[7:0] : m_pc + 8'd1;
          cyc += 2;
        end
        default: begin
          cyc += 2;
          break;
        end
      endcase
    end
  endtask
  task automatic run_prog(input int budget, output int k);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    k = 0;
    sel_hist[0] = bus.alu_sel;
    while (k < budget) begin
      @(negedge clk);
      k++;
      if (k < 1024) sel_hist[k] = bus.alu_sel;
      if (halted) break;
      start = k == 2;
    end
    start = 0;
    chk("halt_reached", halted, 1);
  endtask
  task automatic chk_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1 chk($sformatf("%s_r%0d", tag, i), dbg_data, m_r[i]);
    end
  endtask
  task automatic chk_state(input string tag, input int cyc, input int mcyc);
    chk({tag, "_cyc"}, cyc, mcyc);
    chk_regs(tag);
    chk({tag, "_z"}, flag_z, m_z);
    chk({tag, "_c"}, flag_c, m_c);
    chk({tag, "_pc"}, bus.imem_addr, m_pc);
  endtask
  initial begin
    int cyc, mc, n, kind;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_z = 0;
    m_c = 0;
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_flags", {flag_z, flag_c}, 0);
    chk("rst_imem_rd", bus.imem_rd, 0);
    chk("rst_addr", bus.imem_addr, 0);
    chk("rst_alu", {bus.alu_sel, bus.alu_a, bus.alu_b}, 0);
    chk_regs("rst");
    clear_mem();
    mem[0] = e_ldi(0, 5); mem[1] = e_ldi(1, 3); mem[2] = e_alu(ALU_ADD, 2, 0, 1);
    model_run(mc);
    run_prog(100, cyc);
    chk("t1_cyc", cyc, 12);
    dbg_sel = 2;
    #1 chk("t1_r2", dbg_data, 8'h08);
    chk("t1_z", flag_z, 0);
    chk_state("t1", cyc, mc);
    do_reset();
    clear_mem();
    mem[0] = e_ldi(0, 8'hCC); mem[1] = e_ldi(1, 8'hAA); mem[2] = e_alu(ALU_SUB, 3, 0, 1);
    model_run(mc);
    run_prog(100, cyc);
    dbg_sel = 3;
    #1 chk("t2_r3", dbg_data, 8'h22);
    chk("t2_sel_pre", sel_hist[7], ALU_ADD);
    chk("t2_sel_exec", sel_hist[8], ALU_SUB);
    chk("t2_sel_hold", bus.alu_sel, ALU_SUB);
    chk("t2_a_hold", bus.alu_a, 8'hCC);
    chk_state("t2", cyc, mc);
    do_reset();
    clear_mem();
    mem[0] = e_ldi(0, 7); mem[1] = e_ldi(1, 8'h33); mem[2] = e_alu(ALU_COMP, 1, 0, 0); mem[3] = e_jz(8'h10);
    mem[4] = e_ldi(2, 8'h99);
    model_run(mc);
    run_prog(100, cyc);
    dbg_sel = 1;
    #1 chk("t3_r1_nowrite", dbg_data, 8'h33);
    chk("t3_z", flag_z, 1);
    chk("t3_addr", bus.imem_addr, 8'h10);
    chk("t3_cyc", cyc, 14);
    chk_state("t3", cyc, mc);
    do_reset();
    clear_mem();
    mem[0] = e_ldi(1, 8'h5A); mem[1] = e_alu(ALU_XOR, 1, 1, 1); mem[2] = e_jz(4); mem[3] = e_ldi(0, 8'h11);
    mem[4] = e_ldi(2, 1); mem[5] = e_alu(ALU_ADD, 3, 2, 2); mem[6] = e_jz(8'h40);
    mem[8'h40] = e_ldi(0, 8'hEE);
    model_run(mc);
    run_prog(100, cyc);
    dbg_sel = 0;
    #1 chk("t4_r0", dbg_data, 0);
    dbg_sel = 1;
    #1 chk("t4_r1", dbg_data, 0);
    chk("t4_addr", bus.imem_addr, 7);
    chk("t4_cyc", cyc, 20);
    chk_state("t4", cyc, mc);
    do_reset();
    for (int i = 0; i < 256; i++) mem[i] = e_ldi(0, 8'(i));
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (765) @(negedge clk);
    chk("wrap_addr_ff", bus.imem_addr, 8'hFF);
    chk("wrap_rd_ff", bus.imem_rd, 1);
    repeat (3) @(negedge clk);
    chk("wrap_addr_00", bus.imem_addr, 8'h00);
    chk("wrap_rd_00", bus.imem_rd, 1);
    dbg_sel = 0;
    #1 chk("wrap_r0", dbg_data, 8'hFF);
    do_reset();
    clear_mem();
    mem[0] = e_ldi(0, 5); mem[1] = e_ldi(1, 3); mem[2] = e_alu(ALU_ADD, 2, 0, 1);
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
    repeat (8) @(negedge clk);
    chk("abort_sel", bus.alu_sel, ALU_ADD);
    chk("abort_a", bus.alu_a, 5);
    rst = 1;
    @(negedge clk) rst = 0;
    dbg_sel = 2;
    #1 chk("abort_r2", dbg_data, 0);
    chk("abort_busy", busy, 0);
    chk("abort_halted", halted, 0);
    chk("abort_addr", bus.imem_addr, 0);
    model_run(mc);
    run_prog(100, cyc);
    chk_state("rerun", cyc, mc);
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 5) == 0) do_reset();
      clear_mem();
      n = $urandom_range(3, 24);
      for (int a = 0; a < n; a++) begin
        kind = $urandom_range(0, 9);
        mem[a] = kind < 5 ? e_alu(3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom)) :
                 kind < 8 ? e_ldi(2'($urandom), $urandom_range(0, 3) == 0 ? 8'h00 : 8'($urandom)) :
                 e_jz(8'($urandom_range(a + 1, n)));
      end
      model_run(mc);
      run_prog(mc + 20, cyc);
      chk_state($sformatf("rnd%0d", it), cyc, mc);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
